// File: rtl/interfaz_alu.sv
// Byte-stream front end for the calculadora ALU: collects A, B and opcode from the UART
// receiver, drives the ALU and sends the result byte back. Optional macro FLAGS_TX_EN adds a flags byte.
module interfaz_alu #(
  parameter int BUS     = 8,
  parameter int OP      = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [BUS-1:0] rx_dato,
  input  logic           rx_listo,
  input  logic [BUS-1:0] rdo,
  input  logic           carry,
  input  logic           zero,
  input  logic           tx_ocupado,
  output logic [BUS-1:0] a,
  output logic [BUS-1:0] b,
  output logic [OP-1:0]  op,
  output logic [BUS-1:0] tx_dato,
  output logic           tx_inicio,
  output logic           descartado
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMITE = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

`ifdef FLAGS_TX_EN
  typedef enum logic [2:0] {ESPERA_A, ESPERA_B, ESPERA_OP, CALCULO, ENVIO, ENVIO_FLAGS} estado_t;
  logic [1:0] flags;
  logic       unused_ok;
  assign unused_ok = ^rx_dato[BUS-1:OP];
`else
  typedef enum logic [2:0] {ESPERA_A, ESPERA_B, ESPERA_OP, CALCULO, ENVIO} estado_t;
  logic unused_ok;
  assign unused_ok = ^{carry, zero, rx_dato[BUS-1:OP]};
`endif

  estado_t       estado, estado_sig;
  logic [CW-1:0] cnt;
  logic          guarda;
  logic          inicio;
  logic          descarta;
  logic          expira;

  assign expira    = (TIMEOUT != 0) && (cnt == LIMITE);
  assign tx_inicio = inicio && !reset;

  always_ff @(posedge clk) begin
    if (reset) estado <= ESPERA_A;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    inicio     = 1'b0;
    descarta   = 1'b0;
    case (estado)
      ESPERA_A:  if (rx_listo) estado_sig = ESPERA_B;
      ESPERA_B: begin
        if (rx_listo)    estado_sig = ESPERA_OP;
        else if (expira) estado_sig = ESPERA_A;
      end
      ESPERA_OP: begin
        if (rx_listo)    estado_sig = CALCULO;
        else if (expira) estado_sig = ESPERA_A;
      end
      CALCULO: begin
        descarta   = rx_listo;
        estado_sig = ENVIO;
      end
      ENVIO: begin
        descarta = rx_listo;
        // The transmitter reports busy one cycle late, so skip the cycle after a pulse.
        if (!tx_ocupado && !guarda) begin
          inicio = 1'b1;
`ifdef FLAGS_TX_EN
          estado_sig = ENVIO_FLAGS;
`else
          estado_sig = ESPERA_A;
`endif
        end
      end
`ifdef FLAGS_TX_EN
      ENVIO_FLAGS: begin
        descarta = rx_listo;
        if (!tx_ocupado && !guarda) begin
          inicio     = 1'b1;
          estado_sig = ESPERA_A;
        end
      end
`endif
      default: estado_sig = ESPERA_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a          <= '0;
      b          <= '0;
      op         <= '0;
      tx_dato    <= '0;
      descartado <= 1'b0;
      guarda     <= 1'b0;
      cnt        <= '0;
`ifdef FLAGS_TX_EN
      flags      <= '0;
`endif
    end else begin
      descartado <= descarta;
      guarda     <= inicio;
      case (estado)
        ESPERA_A:  if (rx_listo) a <= rx_dato;
        ESPERA_B:  if (rx_listo) b <= rx_dato;
        ESPERA_OP: if (rx_listo) op <= rx_dato[OP-1:0];
        CALCULO: begin
          tx_dato <= rdo;
`ifdef FLAGS_TX_EN
          flags   <= {carry, zero};
`endif
        end
        default: ;
      endcase
`ifdef FLAGS_TX_EN
      // Load the flags byte only once the result byte has been handed off.
      if (estado == ENVIO && inicio) tx_dato <= {{(BUS-2){1'b0}}, flags};
`endif
      if ((estado == ESPERA_B || estado == ESPERA_OP) && !rx_listo && !expira)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

endmodule
